// File: rtl/matrix_pkg.sv
// Shared register map, CTRL bit positions and swap-state encoding for the
// 8x8 LED matrix frame buffer.
package matrix_pkg;

    localparam int ROWS = 8;

    localparam logic [3:0] ADDR_ROW0   = 4'd0;
    localparam logic [3:0] ADDR_ROW1   = 4'd1;
    localparam logic [3:0] ADDR_ROW2   = 4'd2;
    localparam logic [3:0] ADDR_ROW3   = 4'd3;
    localparam logic [3:0] ADDR_ROW4   = 4'd4;
    localparam logic [3:0] ADDR_ROW5   = 4'd5;
    localparam logic [3:0] ADDR_ROW6   = 4'd6;
    localparam logic [3:0] ADDR_ROW7   = 4'd7;
    localparam logic [3:0] ADDR_CTRL   = 4'd8;
    localparam logic [3:0] ADDR_PERIOD = 4'd9;

    localparam int CTRL_COMMIT     = 0;
    localparam int CTRL_DISP_EN    = 1;
    localparam int CTRL_SCROLL_EN  = 2;
    localparam int CTRL_SCROLL_DIR = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } swap_state_e;

endpackage

// File: rtl/matrix_scroll_rot.sv
// Per-row rotate-by-one of a packed frame; dir=0 rotates each byte left
// (bit7 wraps into bit0), dir=1 rotates right.
module matrix_scroll_rot #(
    parameter int ROWS = 8
) (
    input  logic [8*ROWS-1:0] din,
    input  logic              dir,
    output logic [8*ROWS-1:0] dout
);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [7:0] b;
        assign b = din[8*r +: 8];
        assign dout[8*r +: 8] = dir ? {b[0], b[7:1]} : {b[6:0], b[7]};
    end

endmodule

// File: rtl/matrix_frame_buffer.sv
// Double-buffered 8x8 frame store: bus writes land in the back buffer and
// are copied to the front buffer only on a scan-frame boundary.
module matrix_frame_buffer #(
    parameter int         ROWS       = 8,
    parameter logic [7:0] SCROLL_RST = 8'd1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [7:0]        wr_data,
    output logic [8*ROWS-1:0] data,
    output logic              oe,
    output logic              swap_pending
);

    import matrix_pkg::*;

    logic [8*ROWS-1:0] back;
    logic [8*ROWS-1:0] front;
    logic [8*ROWS-1:0] front_rot;
    logic              disp_en;
    logic              scroll_en;
    logic              scroll_dir;
    logic [7:0]        scroll_period;
    logic [7:0]        frame_cnt;
    logic [2:0]        phase;

    swap_state_e state_q;
    swap_state_e state_d;

    logic row_wr;
    logic ctrl_wr;
    logic period_wr;
    logic commit;
    logic frame_end;
    logic do_swap;
    logic scroll_tick;
    logic scroll_hit;

    always_comb begin
        row_wr      = wr_en && (wr_addr inside {ADDR_ROW0, ADDR_ROW1, ADDR_ROW2, ADDR_ROW3,
                                                ADDR_ROW4, ADDR_ROW5, ADDR_ROW6, ADDR_ROW7});
        ctrl_wr     = wr_en && (wr_addr == ADDR_CTRL);
        period_wr   = wr_en && (wr_addr == ADDR_PERIOD);
        commit      = ctrl_wr && wr_data[CTRL_COMMIT];
        // With the display off every cycle counts as a frame boundary.
        frame_end   = !oe || (phase == 3'd7);
        do_swap     = frame_end && (state_q == ST_PENDING);
        scroll_tick = frame_end && scroll_en && !do_swap;
        scroll_hit  = scroll_tick && (frame_cnt == scroll_period - 8'd1);
    end

    matrix_scroll_rot #(.ROWS(ROWS)) u_rot (
        .din  (front),
        .dir  (scroll_dir),
        .dout (front_rot)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (commit)    state_d = ST_PENDING;
            ST_PENDING: if (frame_end) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        swap_pending = (state_q == ST_PENDING);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            disp_en       <= 1'b0;
            scroll_en     <= 1'b0;
            scroll_dir    <= 1'b0;
            scroll_period <= SCROLL_RST;
            back          <= '0;
        end else begin
            if (ctrl_wr) begin
                disp_en    <= wr_data[CTRL_DISP_EN];
                scroll_en  <= wr_data[CTRL_SCROLL_EN];
                scroll_dir <= wr_data[CTRL_SCROLL_DIR];
            end
            if (period_wr) begin
                scroll_period <= wr_data;
            end
            if (row_wr) begin
                back[{wr_addr[2:0], 3'b000} +: 8] <= wr_data;
            end
        end
    end

    // Phase tracks the driver's row select and sits at 0 whenever oe is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            oe    <= 1'b0;
            phase <= 3'd0;
            data  <= '0;
        end else begin
            oe    <= disp_en;
            phase <= (disp_en && oe) ? phase + 3'd1 : 3'd0;
            data  <= front;
        end
    end

    // Swap outranks a scroll step due on the same boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            front     <= '0;
            frame_cnt <= 8'd0;
        end else begin
            if (do_swap) begin
                front <= back;
            end else if (scroll_hit) begin
                front <= front_rot;
            end
            if (period_wr || do_swap || scroll_hit) begin
                frame_cnt <= 8'd0;
            end else if (scroll_tick) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule
